// File: rtl/chan_segment_pipe_if.sv
// Handshake bundle for one routing-channel segment: upstream side, downstream side and per-tile taps.
interface chan_segment_pipe_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LENGTH     = 4
);
   logic [DATA_WIDTH-1:0]        in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic [DATA_WIDTH-1:0]        out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [LENGTH*DATA_WIDTH-1:0] mid_data;
   logic [LENGTH-1:0]            mid_valid;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, mid_data, mid_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, mid_data, mid_valid
   );
endinterface

// File: rtl/chan_segment_pipe.sv
// Routing-channel segment: combinational bypass or LENGTH-stage elastic pipeline with per-tile taps.
// Mode changes out of PIPE pass through DRAIN so no in-flight word is lost or reordered.
module chan_segment_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int LENGTH     = 4,
   parameter int OCC_W      = $clog2(LENGTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_pipe_en,
   chan_segment_pipe_if.slave seg,
   output logic [OCC_W-1:0] occupancy,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_BYPASS = 2'b00,
      ST_PIPE   = 2'b01,
      ST_DRAIN  = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [LENGTH-1:0]     v_q, v_d;
   logic [DATA_WIDTH-1:0] dat_q [LENGTH];
   logic [DATA_WIDTH-1:0] dat_d [LENGTH];
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [LENGTH-1:0]     adv;
   logic                  in_vld_eff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BYPASS;
         v_q     <= '0;
         occ_q   <= '0;
         for (int i = 0; i < LENGTH; i++) dat_q[i] <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         occ_q   <= occ_d;
         for (int i = 0; i < LENGTH; i++) dat_q[i] <= dat_d[i];
      end
   end

   always_comb begin
      adv        = '0;
      v_d        = v_q;
      occ_d      = '0;
      state_d    = state_q;
      in_vld_eff = seg.in_valid && (state_q == ST_PIPE);
      for (int i = 0; i < LENGTH; i++) dat_d[i] = dat_q[i];

      // Ready ripples back from the output: a stage advances if it is empty or the one ahead advances.
      adv[LENGTH-1] = seg.out_ready || !v_q[LENGTH-1];
      for (int i = LENGTH - 2; i >= 0; i--) adv[i] = adv[i+1] || !v_q[i];

      if (state_q != ST_BYPASS) begin
         if (adv[0]) begin
            v_d[0] = in_vld_eff;
            if (in_vld_eff) dat_d[0] = seg.in_data;
         end
         for (int i = 1; i < LENGTH; i++) begin
            if (adv[i]) begin
               v_d[i] = v_q[i-1];
               if (v_q[i-1]) dat_d[i] = dat_q[i-1];
            end
         end
      end

      for (int i = 0; i < LENGTH; i++) occ_d = occ_d + OCC_W'(v_d[i]);

      case (state_q)
         ST_BYPASS: if (cfg_pipe_en) state_d = ST_PIPE;
         ST_PIPE:   if (!cfg_pipe_en) state_d = ST_DRAIN;
         ST_DRAIN:  if (occ_q == '0) state_d = cfg_pipe_en ? ST_PIPE : ST_BYPASS;
         default:   state_d = ST_BYPASS;
      endcase
   end

   always_comb begin
      seg.in_ready  = 1'b0;
      seg.out_data  = dat_q[LENGTH-1];
      seg.out_valid = v_q[LENGTH-1];
      seg.mid_valid = v_q;
      seg.mid_data  = '0;
      for (int i = 0; i < LENGTH; i++) seg.mid_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];

      case (state_q)
         ST_BYPASS: begin
            seg.in_ready  = seg.out_ready;
            seg.out_data  = seg.in_data;
            seg.out_valid = seg.in_valid;
            seg.mid_data  = {LENGTH{seg.in_data}};
            seg.mid_valid = {LENGTH{seg.in_valid}};
         end
         ST_PIPE:  seg.in_ready = adv[0];
         default:  seg.in_ready = 1'b0;
      endcase
   end

   assign occupancy = occ_q;
   assign state     = state_q;

endmodule

// File: tb/tb_chan_segment_pipe.sv
// Directed bench for chan_segment_pipe with a scoreboard of accepted words checked at the output.
module tb_chan_segment_pipe;
   localparam int DW  = 8;
   localparam int LEN = 4;
   localparam int OW  = $clog2(LEN + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_pipe_en;
   logic [OW-1:0] occupancy;
   logic [1:0]    state;

   chan_segment_pipe_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) sif ();

   chan_segment_pipe #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_pipe_en (cfg_pipe_en),
      .seg         (sif.slave),
      .occupancy   (occupancy),
      .state       (state)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;
   logic          acc;
   logic          lat_chk = 1'b0;
   logic [DW-1:0] exp_q [$];
   int            cyc_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observe handshakes mid-cycle, then advance one clock.
   task automatic step();
      logic [DW-1:0] d;
      int            c;
      @(negedge clk);
      acc = sif.in_valid && sif.in_ready;
      if (acc) begin
         exp_q.push_back(sif.in_data);
         cyc_q.push_back(cyc);
      end
      if (sif.out_valid && sif.out_ready) begin
         check("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            d = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("sb_data", sif.out_data, d);
            if (lat_chk) check("latency", cyc - c, LEN);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      sif.in_data  = d;
      sif.in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         step();
         if (acc) break;
      end
      check("send_accept", acc, 1);
   endtask

   task automatic drain_sb(input string tag);
      for (int n = 0; n < 40 && exp_q.size() > 0; n++) step();
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      cfg_pipe_en   = 1'b0;
      sif.in_data   = '0;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      #2;
      check("rst_state", state, 2'b00);
      check("rst_occ", occupancy, 0);
      check("rst_mid_valid", sif.mid_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Bypass: combinational pass-through to output and all taps
      sif.in_data  = 8'h5A;
      sif.in_valid = 1'b1;
      #1;
      check("byp_out_data", sif.out_data, 8'h5A);
      check("byp_out_valid", sif.out_valid, 1);
      check("byp_in_ready", sif.in_ready, 1);
      check("byp_mid_data", sif.mid_data, 32'h5A5A5A5A);
      check("byp_mid_valid", sif.mid_valid, 4'hF);
      check("byp_occ", occupancy, 0);
      sif.out_ready = 1'b0;
      #1;
      check("byp_in_ready_bp", sif.in_ready, 0);
      sif.out_ready = 1'b1;
      step();
      check("byp_sb", exp_q.size(), 0);
      sif.in_valid = 1'b0;

      // Enter PIPE
      cfg_pipe_en = 1'b1;
      step();
      check("to_pipe", state, 2'b01);

      // Back-to-back stream, latency LENGTH and full throughput
      lat_chk = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         send(DW'(i));
         if (i == 10) check("stream_occ", occupancy, LEN);
      end
      sif.in_valid = 1'b0;
      drain_sb("stream_empty");
      lat_chk = 1'b0;
      check("stream_occ_end", occupancy, 0);

      // Fill against backpressure
      sif.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'hA0 + DW'(i));
      sif.in_data = 8'hA4;
      #1;
      check("full_in_ready", sif.in_ready, 0);
      check("full_occ", occupancy, LEN);
      check("full_mid_valid", sif.mid_valid, 4'hF);
      check("full_mid_data", sif.mid_data, 32'hA0A1A2A3);
      step();
      check("full_no_accept", acc, 0);
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      drain_sb("fill_empty");

      // Drop cfg with 3 words in flight
      sif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(8'hB0 + DW'(i));
      sif.in_valid = 1'b0;
      check("drn_occ3", occupancy, 3);
      cfg_pipe_en = 1'b0;
      step();
      check("to_drain", state, 2'b10);
      sif.in_data  = 8'hCC;
      sif.in_valid = 1'b1;
      #1;
      check("drain_in_ready", sif.in_ready, 0);
      sif.out_ready = 1'b1;
      step();
      sif.in_valid = 1'b0;
      for (int n = 0; n < LEN + 3 && state != 2'b00; n++) step();
      check("drain_to_bypass", state, 2'b00);
      check("drain_sb_empty", exp_q.size(), 0);
      check("drain_occ", occupancy, 0);

      // cfg pulses during DRAIN do not abort it
      cfg_pipe_en = 1'b1;
      step();
      sif.out_ready = 1'b0;
      send(8'hD0);
      send(8'hD1);
      sif.in_valid = 1'b0;
      cfg_pipe_en  = 1'b0;
      step();
      check("pulse_drain", state, 2'b10);
      cfg_pipe_en = 1'b1;
      step();
      cfg_pipe_en = 1'b0;
      step();
      cfg_pipe_en = 1'b1;
      step();
      check("pulse_still_drain", state, 2'b10);
      sif.out_ready = 1'b1;
      for (int n = 0; n < LEN + 3 && state == 2'b10; n++) step();
      check("pulse_to_pipe", state, 2'b01);
      check("pulse_sb_empty", exp_q.size(), 0);

      // Asynchronous reset mid-operation
      sif.out_ready = 1'b0;
      send(8'hE0);
      send(8'hE1);
      sif.in_valid = 1'b0;
      check("pre_rst_occ", occupancy, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", state, 2'b00);
      check("arst_occ", occupancy, 0);
      check("arst_mid_valid", sif.mid_valid, 0);
      exp_q.delete();
      cyc_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
